fifo_nw_1r_sync: RTL and testbench
==================================

Name: fifo_nw_1r_sync

Overview:
- Single-clock FIFO accepting 0..WR_PORTS entries per cycle on a packed multi-lane write port, with one entry read per cycle.
- Generalises the two-writes/one-read buffer used between SMEM pipeline stages.
- Adds real full/empty, occupancy count, an almost-full threshold, all-or-nothing write acceptance with overflow detection, and a synchronous flush.
- Sits between the multi-result producer stages and single-result consumer stages.

Parameters:
- DATA_WIDTH, 65, bits per entry.
- ADDRESS_WIDTH, 4, log2 of depth.
- FIFO_DEPTH, 1<<ADDRESS_WIDTH, entries; must be a power of two and >= WR_PORTS.
- WR_PORTS, 2, maximum entries written per cycle; range 1..4.
- WCNT_WIDTH, 2, width of WriteCount_in; must satisfy 2^WCNT_WIDTH > WR_PORTS.
- AFULL_THRESH, FIFO_DEPTH-WR_PORTS, Almost_full_out asserts when count >= this value.

Ports:
- Clk  in  1  clock.
- Reset_n  in  1  asynchronous active-low reset.
- Clear_in  in  1  synchronous flush, active high.
- Data_in  in  WR_PORTS*DATA_WIDTH  packed lanes; lane 0 is bits [DATA_WIDTH-1:0] and is written first.
- WriteCount_in  in  WCNT_WIDTH  number of lanes to write this cycle (lanes 0..n-1); 0 means no write.
- Write_ready_out  out  1  high when free space >= WR_PORTS.
- Full_out  out  1  count == FIFO_DEPTH.
- Almost_full_out  out  1  count >= AFULL_THRESH.
- Overflow_out  out  1  one-cycle pulse when a write is rejected.
- ReadEn_in  in  1  read request.
- Data_out  out  DATA_WIDTH  read data, registered.
- Data_valid  out  1  one-cycle pulse qualifying Data_out.
- Empty_out  out  1  count == 0.
- Count_out  out  ADDRESS_WIDTH+1  current occupancy.

Behaviour:
- Clocking and reset:
  - One clock, Clk. Reset is asynchronous and active-low, on Reset_n.
  - During reset: read and write pointers = 0, count = 0, Data_valid = 0, Data_out = 0, Overflow_out = 0.
  - Memory contents are not reset.
- Flags:
  - Status flags are combinational from the count register: Empty_out=1, Full_out=0, Almost_full_out=(AFULL_THRESH==0), Write_ready_out=1 after reset.
- Pointers:
  - Binary, ADDRESS_WIDTH bits, wrap modulo FIFO_DEPTH.
  - Count is held separately in ADDRESS_WIDTH+1 bits.
- Write:
  - Let n = WriteCount_in and free = FIFO_DEPTH - count (count at the start of the cycle).
  - If 0 < n <= free: lane k is stored at (wptr+k) mod DEPTH for k < n, and wptr advances by n.
  - If n > free: the whole write is dropped (no partial write), wptr is unchanged, and Overflow_out pulses high next cycle.
  - n > WR_PORTS is illegal: treat as overflow, no write.
- Read:
  - ReadEn_in with count > 0: Data_out <= mem[rptr], Data_valid=1 next cycle, rptr+1. Latency is 1 cycle.
  - ReadEn_in with count == 0: ignored, Data_valid=0, Data_out holds its value.
- Simultaneous read and write:
  - free is evaluated on the pre-read count, so a read in the same cycle does not create space for the write.
  - count_next = count + n_accepted - r_accepted.
  - A read of an entry written in the same cycle is impossible, since count was 0 and the read is ignored.
- Wrap-around:
  - A multi-lane write that straddles the end of memory splits across DEPTH-1 and 0 transparently.
- Clear_in (synchronous, higher priority than read/write):
  - Pointers and count go to 0, Data_valid=0 next cycle, Overflow_out=0.
  - Writes and reads in the same cycle are discarded.
- Reset mid-operation:
  - Immediate asynchronous return to reset state.
  - Any Data_valid in flight is cancelled.
- Full_out and Empty_out are never asserted together.
- Every output except the status flags is registered.

Optional Feature:
- Macro FIFO_ERR_STATS_EN.
- When defined:
  - Adds an output Drop_count_out, 16 bits, counting rejected write lanes (adds n per rejected write). It saturates at 0xFFFF.
  - Adds an output Underflow_out, 1 bit, a sticky flag set by ReadEn_in while empty.
  - Both are cleared by Reset_n or Clear_in.
- When undefined: neither port exists, and the remaining behaviour is identical.

Test Plan:
- Reset then idle: Reset_n low for 3 cycles -> Empty_out=1, Count_out=0, Write_ready_out=1, Data_valid=0.
- Dual write, then drain (DEPTH=16, WR_PORTS=2):
  - WriteCount_in=2 with lanes 0xA,0xB, then n=1 with 0xC -> Count_out=3.
  - 3 reads -> Data_out 0xA, 0xB, 0xC on consecutive Data_valid pulses, each 1 cycle after ReadEn_in; then Empty_out=1.
- Fill and overflow:
  - Fill 15 entries, then write n=2 -> rejected, Overflow_out pulse, Count_out stays 15.
  - Then n=1 -> Full_out=1, Count_out=16.
- Wrap-around straddle:
  - Advance pointers to wptr=15 and rptr=15 (empty), then write n=2 lanes 0x1,0x2.
  - Read 2 -> 0x1 then 0x2; Count_out returns to 0.
- Simultaneous read and write at count=15:
  - Read plus n=2 -> write rejected (free=1), read accepted, Count_out=14.
  - Read plus n=1 at count=15 -> Count_out=15.
- Flush and async reset:
  - Clear_in at count=9 while ReadEn_in=1 -> Count_out=0, no Data_valid.
  - Reset_n pulled low mid-stream -> all outputs take reset values in the same cycle, no clock edge required.

Source files
------------

// File: rtl/fifo_nw_1r_sync_if.sv
// Bundle of the multi-lane write / single read FIFO signals; the master side drives inputs, the slave side is the FIFO.
// Optional error statistics ports appear when FIFO_ERR_STATS_EN is defined.
interface fifo_nw_1r_sync_if #(
    parameter int DATA_WIDTH    = 65,
    parameter int ADDRESS_WIDTH = 4,
    parameter int WR_PORTS      = 2,
    parameter int WCNT_WIDTH    = 2
);
    logic                           Clear_in;
    logic [WR_PORTS*DATA_WIDTH-1:0] Data_in;
    logic [WCNT_WIDTH-1:0]          WriteCount_in;
    logic                           Write_ready_out;
    logic                           Full_out;
    logic                           Almost_full_out;
    logic                           Overflow_out;
    logic                           ReadEn_in;
    logic [DATA_WIDTH-1:0]          Data_out;
    logic                           Data_valid;
    logic                           Empty_out;
    logic [ADDRESS_WIDTH:0]         Count_out;
`ifdef FIFO_ERR_STATS_EN
    logic [15:0]                    Drop_count_out;
    logic                           Underflow_out;

    modport master (
        output Clear_in, Data_in, WriteCount_in, ReadEn_in,
        input  Write_ready_out, Full_out, Almost_full_out, Overflow_out,
        input  Data_out, Data_valid, Empty_out, Count_out,
        input  Drop_count_out, Underflow_out
    );

    modport slave (
        input  Clear_in, Data_in, WriteCount_in, ReadEn_in,
        output Write_ready_out, Full_out, Almost_full_out, Overflow_out,
        output Data_out, Data_valid, Empty_out, Count_out,
        output Drop_count_out, Underflow_out
    );
`else
    modport master (
        output Clear_in, Data_in, WriteCount_in, ReadEn_in,
        input  Write_ready_out, Full_out, Almost_full_out, Overflow_out,
        input  Data_out, Data_valid, Empty_out, Count_out
    );

    modport slave (
        input  Clear_in, Data_in, WriteCount_in, ReadEn_in,
        output Write_ready_out, Full_out, Almost_full_out, Overflow_out,
        output Data_out, Data_valid, Empty_out, Count_out
    );
`endif
endinterface

// File: rtl/fifo_nw_1r_sync.sv
// Single-clock FIFO: up to WR_PORTS entries written per cycle (all-or-nothing), one registered read per cycle.
// Define FIFO_ERR_STATS_EN to add Drop_count_out (rejected lanes, saturating) and sticky Underflow_out.
module fifo_nw_1r_sync #(
    parameter int DATA_WIDTH    = 65,
    parameter int ADDRESS_WIDTH = 4,
    parameter int FIFO_DEPTH    = 1 << ADDRESS_WIDTH,
    parameter int WR_PORTS      = 2,
    parameter int WCNT_WIDTH    = 2,
    parameter int AFULL_THRESH  = FIFO_DEPTH - WR_PORTS
) (
    input  logic              Clk,
    input  logic              Reset_n,
    fifo_nw_1r_sync_if.slave  io
);
    localparam int CW = ADDRESS_WIDTH + 1;
    localparam logic [CW-1:0]         DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0]         AFULL_C = CW'(AFULL_THRESH);
    localparam logic [CW-1:0]         PORTS_C = CW'(WR_PORTS);
    localparam logic [WCNT_WIDTH-1:0] NMAX_C  = WCNT_WIDTH'(WR_PORTS);

    logic [DATA_WIDTH-1:0]    r_mem [FIFO_DEPTH];
    logic [ADDRESS_WIDTH-1:0] r_wptr;
    logic [ADDRESS_WIDTH-1:0] r_rptr;
    logic [CW-1:0]            r_count;
    logic [DATA_WIDTH-1:0]    r_data_out;
    logic                     r_data_valid;
    logic                     r_overflow;

    logic [CW-1:0]            w_free;
    logic [CW-1:0]            w_n_ext;
    logic [CW-1:0]            w_count_next;
    logic [ADDRESS_WIDTH-1:0] w_wptr_next;
    logic                     w_wr_ok;
    logic                     w_wr_reject;
    logic                     w_rd_ok;
    logic [WR_PORTS-1:0]      w_lane_we;
    logic [ADDRESS_WIDTH-1:0] w_lane_addr [WR_PORTS];
    logic [DATA_WIDTH-1:0]    w_lane_data [WR_PORTS];

    // Space is judged on the pre-read count, so a same-cycle read never makes room for a write.
    always_comb begin
        w_free       = DEPTH_C - r_count;
        w_n_ext      = CW'(io.WriteCount_in);
        w_wr_ok      = (io.WriteCount_in != '0) && (io.WriteCount_in <= NMAX_C) && (w_n_ext <= w_free);
        w_wr_reject  = (io.WriteCount_in != '0) && !w_wr_ok;
        w_rd_ok      = io.ReadEn_in && (r_count != '0);
        w_wptr_next  = r_wptr;
        w_count_next = r_count;
        if (w_wr_ok) begin
            w_wptr_next  = r_wptr + ADDRESS_WIDTH'(io.WriteCount_in);
            w_count_next = w_count_next + w_n_ext;
        end
        if (w_rd_ok) begin
            w_count_next = w_count_next - CW'(1);
        end
    end

    // Lane addresses wrap naturally in ADDRESS_WIDTH bits, so a straddling write splits across the end.
    for (genvar gi = 0; gi < WR_PORTS; gi++) begin : g_lane
        localparam logic [WCNT_WIDTH-1:0] LANE_N = WCNT_WIDTH'(gi);
        assign w_lane_we[gi]   = w_wr_ok && !io.Clear_in && (LANE_N < io.WriteCount_in);
        assign w_lane_addr[gi] = r_wptr + ADDRESS_WIDTH'(gi);
        assign w_lane_data[gi] = io.Data_in[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    always_ff @(posedge Clk) begin
        for (int k = 0; k < WR_PORTS; k++) begin
            if (w_lane_we[k]) begin
                r_mem[w_lane_addr[k]] <= w_lane_data[k];
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_overflow   <= 1'b0;
        end else if (io.Clear_in) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_data_valid <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_overflow   <= w_wr_reject;
            r_data_valid <= w_rd_ok;
            r_wptr       <= w_wptr_next;
            r_count      <= w_count_next;
            if (w_rd_ok) begin
                r_data_out <= r_mem[r_rptr];
                r_rptr     <= r_rptr + ADDRESS_WIDTH'(1);
            end
        end
    end

`ifdef FIFO_ERR_STATS_EN
    logic [15:0] r_drop_count;
    logic        r_underflow;
    logic [16:0] w_drop_sum;

    assign w_drop_sum = {1'b0, r_drop_count} + 17'(io.WriteCount_in);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_drop_count <= '0;
            r_underflow  <= 1'b0;
        end else if (io.Clear_in) begin
            r_drop_count <= '0;
            r_underflow  <= 1'b0;
        end else begin
            if (w_wr_reject) begin
                r_drop_count <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
            end
            if (io.ReadEn_in && (r_count == '0)) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign io.Drop_count_out = r_drop_count;
    assign io.Underflow_out  = r_underflow;
`endif

    assign io.Data_out        = r_data_out;
    assign io.Data_valid      = r_data_valid;
    assign io.Overflow_out    = r_overflow;
    assign io.Count_out       = r_count;
    assign io.Empty_out       = (r_count == '0);
    assign io.Full_out        = (r_count == DEPTH_C);
    assign io.Almost_full_out = (r_count >= AFULL_C);
    assign io.Write_ready_out = (w_free >= PORTS_C);
endmodule

// File: tb/tb_fifo_nw_1r_sync.sv
// Self-checking bench for fifo_nw_1r_sync: queue scoreboard filled on accepted writes, drained on accepted reads.
module tb_fifo_nw_1r_sync;
    localparam int DW    = 65;
    localparam int AW    = 4;
    localparam int WP    = 2;
    localparam int NW    = 2;
    localparam int DEPTH = 16;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    always #5 Clk = ~Clk;

    fifo_nw_1r_sync_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .WR_PORTS(WP), .WCNT_WIDTH(NW)) io ();

    fifo_nw_1r_sync #(
        .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .FIFO_DEPTH(DEPTH),
        .WR_PORTS(WP), .WCNT_WIDTH(NW), .AFULL_THRESH(DEPTH - WP)
    ) dut (
        .Clk(Clk),
        .Reset_n(Reset_n),
        .io(io)
    );

    int checks = 0;
    int errors = 0;

    int            m_count;
    int            m_wptr;
    logic [DW-1:0] sb [$];
    bit            exp_valid;
    bit            exp_ovf;
    logic [DW-1:0] exp_data;
`ifdef FIFO_ERR_STATS_EN
    int            m_drop;
    bit            m_uflow;
`endif

    task automatic model_reset();
        m_count   = 0;
        m_wptr    = 0;
        sb.delete();
        exp_valid = 0;
        exp_ovf   = 0;
        exp_data  = '0;
`ifdef FIFO_ERR_STATS_EN
        m_drop  = 0;
        m_uflow = 0;
`endif
    endtask

    // Drive one cycle of stimulus, update the reference model, and stop 1 time unit after the edge.
    task automatic drive(input int n, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                         input bit rd, input bit clr);
        int  free;
        bit  wr_ok;
        bit  rd_ok;
        io.WriteCount_in = NW'(n);
        io.Data_in       = {d1, d0};
        io.ReadEn_in     = rd;
        io.Clear_in      = clr;
        if (clr) begin
            m_count   = 0;
            m_wptr    = 0;
            sb.delete();
            exp_valid = 0;
            exp_ovf   = 0;
`ifdef FIFO_ERR_STATS_EN
            m_drop  = 0;
            m_uflow = 0;
`endif
        end else begin
            free  = DEPTH - m_count;
            wr_ok = (n != 0) && (n <= WP) && (n <= free);
            rd_ok = rd && (m_count > 0);
            exp_ovf = (n != 0) && !wr_ok;
`ifdef FIFO_ERR_STATS_EN
            if (exp_ovf) m_drop = (m_drop + n > 16'hFFFF) ? 16'hFFFF : m_drop + n;
            if (rd && m_count == 0) m_uflow = 1;
`endif
            exp_valid = rd_ok;
            if (rd_ok && sb.size() > 0) exp_data = sb.pop_front();
            if (wr_ok) begin
                sb.push_back(d0);
                if (n == 2) sb.push_back(d1);
                m_wptr = (m_wptr + n) % DEPTH;
            end
            m_count = m_count + (wr_ok ? n : 0) - (rd_ok ? 1 : 0);
        end
        @(posedge Clk);
        #1;
        $display("txn n=%0d rd=%0d clr=%0d -> count=%0d valid=%0d ovf=%0d data=%0h",
                 n, rd, clr, io.Count_out, io.Data_valid, io.Overflow_out, io.Data_out);
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        checks++; if (io.Empty_out !== 1'b1) begin errors++; $display("FAIL reset_empty got %0b want 1", io.Empty_out); end
        checks++; if (io.Count_out !== 5'd0) begin errors++; $display("FAIL reset_count got %0d want 0", io.Count_out); end
        checks++; if (io.Write_ready_out !== 1'b1) begin errors++; $display("FAIL reset_wready got %0b want 1", io.Write_ready_out); end
        checks++; if (io.Data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", io.Data_valid); end
        checks++; if (io.Full_out !== 1'b0 || io.Almost_full_out !== 1'b0 || io.Overflow_out !== 1'b0)
            begin errors++; $display("FAIL reset_flags got full=%0b afull=%0b ovf=%0b want 0 0 0", io.Full_out, io.Almost_full_out, io.Overflow_out); end
        checks++; if (io.Data_out !== '0) begin errors++; $display("FAIL reset_data got %0h want 0", io.Data_out); end
        Reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_dual_write_drain();
        drive(2, DW'('hA), DW'('hB), 0, 0);
        checks++; if (io.Count_out !== 5'(m_count)) begin errors++; $display("FAIL dual_count2 got %0d want %0d", io.Count_out, m_count); end
        drive(1, DW'('hC), DW'('h0), 0, 0);
        checks++; if (io.Count_out !== 5'd3) begin errors++; $display("FAIL dual_count3 got %0d want 3", io.Count_out); end
        for (int i = 0; i < 3; i++) begin
            drive(0, '0, '0, 1, 0);
            checks++; if (io.Data_valid !== 1'b1 || io.Data_out !== exp_data)
                begin errors++; $display("FAIL drain_data[%0d] got valid=%0b data=%0h want 1 %0h", i, io.Data_valid, io.Data_out, exp_data); end
        end
        drive(0, '0, '0, 0, 0);
        checks++; if (io.Data_valid !== 1'b0 || io.Empty_out !== 1'b1)
            begin errors++; $display("FAIL drain_end got valid=%0b empty=%0b want 0 1", io.Data_valid, io.Empty_out); end
    endtask

    task automatic test_fill_overflow();
        drive(3, DW'('h77), DW'('h78), 0, 0);
        checks++; if (io.Overflow_out !== 1'b1 || io.Count_out !== 5'd0)
            begin errors++; $display("FAIL illegal_n got ovf=%0b count=%0d want 1 0", io.Overflow_out, io.Count_out); end
        for (int i = 0; i < 7; i++) drive(2, DW'(100 + 2*i), DW'(101 + 2*i), 0, 0);
        drive(1, DW'(114), '0, 0, 0);
        checks++; if (io.Count_out !== 5'd15 || io.Almost_full_out !== 1'b1 || io.Write_ready_out !== 1'b0)
            begin errors++; $display("FAIL fill15 got count=%0d afull=%0b wready=%0b want 15 1 0", io.Count_out, io.Almost_full_out, io.Write_ready_out); end
        drive(2, DW'('hBAD), DW'('hBAD), 0, 0);
        checks++; if (io.Overflow_out !== 1'b1 || io.Count_out !== 5'd15)
            begin errors++; $display("FAIL overflow got ovf=%0b count=%0d want 1 15", io.Overflow_out, io.Count_out); end
        drive(1, DW'(115), '0, 0, 0);
        checks++; if (io.Overflow_out !== 1'b0 || io.Full_out !== 1'b1 || io.Count_out !== 5'd16 || io.Empty_out !== 1'b0)
            begin errors++; $display("FAIL full got ovf=%0b full=%0b count=%0d empty=%0b want 0 1 16 0", io.Overflow_out, io.Full_out, io.Count_out, io.Empty_out); end
        drive(1, DW'('hBAD), '0, 0, 0);
        checks++; if (io.Overflow_out !== 1'b1) begin errors++; $display("FAIL overflow_full got %0b want 1", io.Overflow_out); end
        for (int i = 0; i < 16; i++) begin
            drive(0, '0, '0, 1, 0);
            checks++; if (io.Data_valid !== 1'b1 || io.Data_out !== exp_data)
                begin errors++; $display("FAIL fill_drain[%0d] got valid=%0b data=%0h want 1 %0h", i, io.Data_valid, io.Data_out, exp_data); end
        end
        checks++; if (io.Empty_out !== 1'b1) begin errors++; $display("FAIL fill_empty got %0b want 1", io.Empty_out); end
    endtask

    task automatic test_wrap();
        while (m_wptr != 15) begin
            drive(1, DW'(m_wptr), '0, 0, 0);
            drive(0, '0, '0, 1, 0);
        end
        drive(2, DW'('h1), DW'('h2), 0, 0);
        checks++; if (io.Count_out !== 5'd2) begin errors++; $display("FAIL wrap_count got %0d want 2", io.Count_out); end
        for (int i = 0; i < 2; i++) begin
            drive(0, '0, '0, 1, 0);
            checks++; if (io.Data_valid !== 1'b1 || io.Data_out !== DW'(i + 1))
                begin errors++; $display("FAIL wrap_data[%0d] got valid=%0b data=%0h want 1 %0h", i, io.Data_valid, io.Data_out, i + 1); end
        end
        checks++; if (io.Count_out !== 5'd0) begin errors++; $display("FAIL wrap_end got %0d want 0", io.Count_out); end
    endtask

    task automatic test_simul_rw();
        for (int i = 0; i < 7; i++) drive(2, DW'(200 + 2*i), DW'(201 + 2*i), 0, 0);
        drive(1, DW'(214), '0, 0, 0);
        drive(2, DW'('hBAD), DW'('hBAD), 1, 0);
        checks++; if (io.Overflow_out !== 1'b1 || io.Data_valid !== 1'b1 || io.Data_out !== DW'(200) || io.Count_out !== 5'd14)
            begin errors++; $display("FAIL rw_reject got ovf=%0b valid=%0b data=%0h count=%0d want 1 1 c8 14", io.Overflow_out, io.Data_valid, io.Data_out, io.Count_out); end
        drive(1, DW'(215), '0, 0, 0);
        drive(1, DW'(216), '0, 1, 0);
        checks++; if (io.Overflow_out !== 1'b0 || io.Data_out !== DW'(201) || io.Count_out !== 5'd15)
            begin errors++; $display("FAIL rw_accept got ovf=%0b data=%0h count=%0d want 0 c9 15", io.Overflow_out, io.Data_out, io.Count_out); end
        while (m_count > 0) drive(0, '0, '0, 1, 0);
        checks++; if (io.Data_out !== DW'(216)) begin errors++; $display("FAIL rw_last got %0h want d8", io.Data_out); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 4; i++) drive(2, DW'(300 + 2*i), DW'(301 + 2*i), 0, 0);
        drive(1, DW'(308), '0, 0, 0);
        checks++; if (io.Count_out !== 5'd9) begin errors++; $display("FAIL flush_pre got %0d want 9", io.Count_out); end
        drive(2, DW'('hBAD), DW'('hBAD), 1, 1);
        checks++; if (io.Count_out !== 5'd0 || io.Data_valid !== 1'b0 || io.Empty_out !== 1'b1 || io.Overflow_out !== 1'b0)
            begin errors++; $display("FAIL flush got count=%0d valid=%0b empty=%0b ovf=%0b want 0 0 1 0", io.Count_out, io.Data_valid, io.Empty_out, io.Overflow_out); end
        drive(1, DW'('h55), '0, 0, 0);
        drive(0, '0, '0, 1, 0);
        checks++; if (io.Data_valid !== 1'b1 || io.Data_out !== DW'('h55))
            begin errors++; $display("FAIL flush_after got valid=%0b data=%0h want 1 55", io.Data_valid, io.Data_out); end
    endtask

    task automatic test_async_reset();
        drive(2, DW'('h61), DW'('h62), 0, 0);
        drive(0, '0, '0, 1, 0);
        checks++; if (io.Data_valid !== 1'b1 || io.Data_out !== DW'('h61))
            begin errors++; $display("FAIL areset_pre got valid=%0b data=%0h want 1 61", io.Data_valid, io.Data_out); end
        io.ReadEn_in = 1'b0;
        Reset_n = 1'b0;
        #1;
        checks++; if (io.Data_valid !== 1'b0 || io.Count_out !== 5'd0 || io.Empty_out !== 1'b1 || io.Data_out !== '0 || io.Write_ready_out !== 1'b1)
            begin errors++; $display("FAIL areset got valid=%0b count=%0d empty=%0b data=%0h wready=%0b want 0 0 1 0 1", io.Data_valid, io.Count_out, io.Empty_out, io.Data_out, io.Write_ready_out); end
        #1;
        Reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_back_to_back();
        logic [95:0]   t0;
        logic [95:0]   t1;
        int            n;
        bit            rd;
        bit            clr;
        for (int i = 0; i < 300; i++) begin
            t0  = {$urandom(), $urandom(), $urandom()};
            t1  = {$urandom(), $urandom(), $urandom()};
            n   = int'($urandom_range(0, 3));
            rd  = ($urandom_range(0, 2) != 0);
            clr = ($urandom_range(0, 40) == 0);
            drive(n, t0[DW-1:0], t1[DW-1:0], rd, clr);
            checks++; if (io.Count_out !== 5'(m_count) || io.Data_valid !== exp_valid || io.Data_out !== exp_data || io.Overflow_out !== exp_ovf)
                begin errors++; $display("FAIL b2b[%0d] got count=%0d valid=%0b data=%0h ovf=%0b want %0d %0b %0h %0b", i, io.Count_out, io.Data_valid, io.Data_out, io.Overflow_out, m_count, exp_valid, exp_data, exp_ovf); end
            checks++; if (io.Empty_out !== (m_count == 0) || io.Full_out !== (m_count == DEPTH) ||
                          io.Almost_full_out !== (m_count >= DEPTH - WP) || io.Write_ready_out !== (DEPTH - m_count >= WP))
                begin errors++; $display("FAIL b2b_flags[%0d] got e=%0b f=%0b af=%0b wr=%0b at count %0d", i, io.Empty_out, io.Full_out, io.Almost_full_out, io.Write_ready_out, m_count); end
`ifdef FIFO_ERR_STATS_EN
            checks++; if (io.Drop_count_out !== 16'(m_drop) || io.Underflow_out !== m_uflow)
                begin errors++; $display("FAIL b2b_stats[%0d] got drop=%0d uflow=%0b want %0d %0b", i, io.Drop_count_out, io.Underflow_out, m_drop, m_uflow); end
`endif
        end
    endtask

    initial begin
        io.Clear_in      = 1'b0;
        io.Data_in       = '0;
        io.WriteCount_in = '0;
        io.ReadEn_in     = 1'b0;
        model_reset();
        test_reset();
        test_dual_write_drain();
        test_fill_overflow();
        test_wrap();
        test_simul_rw();
        test_flush();
        test_async_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
